// File: rtl/regfile_sb_pkg.sv
// Shared RISC-V core types: integer register width, register address width
// and the index of the architectural zero register.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ZERO_IDX   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xword_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one pending bit per register, set by issue and
// cleared by writeback (issue wins on a tie), plus RAW/WAW hazard detection.
module rf_scoreboard
    import rv_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        A1,
    input  logic [ADDR_W-1:0]        A2,
    input  logic                     rs1_used,
    input  logic                     rs2_used,
    input  logic                     WE3,
    input  logic [ADDR_W-1:0]        A3,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_rd,
    output logic                     raw_hazard,
    output logic                     waw_hazard,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int                DEPTH   = 2**ADDR_W;
    localparam bit                ZR      = (ZERO_REG != 0);
    localparam bit                BP      = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_IDX);

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] set_s;
    logic [DEPTH-1:0] clr_s;
    logic [DEPTH-1:0] busy_nxt_s;
    logic             raw1_s;
    logic             raw2_s;

    // Per-entry set/clear decode; a new producer outranks a retiring one.
    always_comb begin
        set_s      = {DEPTH{1'b0}};
        clr_s      = {DEPTH{1'b0}};
        busy_nxt_s = busy_r;
        for (int r = 0; r < DEPTH; r++) begin
            set_s[r] = iss_valid && (iss_rd == ADDR_W'(r)) && !(ZR && (r == ZERO_IDX));
            clr_s[r] = WE3 && (A3 == ADDR_W'(r));
            if (set_s[r]) begin
                busy_nxt_s[r] = 1'b1;
            end else if (clr_s[r]) begin
                busy_nxt_s[r] = 1'b0;
            end else begin
                busy_nxt_s[r] = busy_r[r];
            end
        end
    end

    // Busy bits; reset drops every outstanding producer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Hazards: a source being written back this cycle is satisfied only
    // when the bypass path can deliver it; x0 never stalls.
    always_comb begin
        raw1_s = rs1_used && busy_r[A1] && !(ZR && (A1 == ZERO_A));
        if (BP && WE3 && (A3 == A1)) begin
            raw1_s = 1'b0;
        end else begin
            raw1_s = raw1_s;
        end
        raw2_s = rs2_used && busy_r[A2] && !(ZR && (A2 == ZERO_A));
        if (BP && WE3 && (A3 == A2)) begin
            raw2_s = 1'b0;
        end else begin
            raw2_s = raw2_s;
        end
        raw_hazard = raw1_s || raw2_s;
        waw_hazard = iss_valid && busy_r[iss_rd] && !(WE3 && (A3 == iss_rd))
                     && !(ZR && (iss_rd == ZERO_A));
    end

    assign busy_vec = busy_r;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: two combinational read ports, one write port,
// optional hardwired x0, optional same-cycle write forwarding, and an
// attached busy-bit scoreboard for pipeline stall decisions.
module regfile_sb
    import rv_pkg::*;
#(
    parameter int WIDTH    = XLEN,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        A1,
    input  logic [ADDR_W-1:0]        A2,
    output logic [WIDTH-1:0]         RD1,
    output logic [WIDTH-1:0]         RD2,
    input  logic                     WE3,
    input  logic [ADDR_W-1:0]        A3,
    input  logic [WIDTH-1:0]         WD3,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_rd,
    input  logic                     rs1_used,
    input  logic                     rs2_used,
    output logic                     raw_hazard,
    output logic                     waw_hazard,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int                DEPTH  = 2**ADDR_W;
    localparam bit                ZR     = (ZERO_REG != 0);
    localparam bit                BP     = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_en_s;

    // Writes to a hardwired x0 are dropped before reaching the array.
    assign wr_en_s = WE3 && !(ZR && (A3 == ZERO_A));

    // Storage array, cleared asynchronously so reads are defined after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[A3] <= WD3;
        end
    end

    // Read port 1: x0 constant, then forwarded writeback, then array.
    always_comb begin
        if (ZR && (A1 == ZERO_A)) begin
            RD1 = {WIDTH{1'b0}};
        end else if (BP && wr_en_s && (A3 == A1)) begin
            RD1 = WD3;
        end else begin
            RD1 = mem_r[A1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        if (ZR && (A2 == ZERO_A)) begin
            RD2 = {WIDTH{1'b0}};
        end else if (BP && wr_en_s && (A3 == A2)) begin
            RD2 = WD3;
        end else begin
            RD2 = mem_r[A2];
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .A1         (A1),
        .A2         (A2),
        .rs1_used   (rs1_used),
        .rs2_used   (rs2_used),
        .WE3        (WE3),
        .A3         (A3),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .raw_hazard (raw_hazard),
        .waw_hazard (waw_hazard),
        .busy_vec   (busy_vec)
    );

endmodule
